// File: rtl/div_share_sched_pkg.sv
// div_share_pkg: shared state encoding and default widths for the shared
// non-restoring divider scheduler.
package div_share_pkg;
    localparam int DW_DEF = 8;
    localparam int BW_DEF = 4;
    localparam logic [63:0] DBZ_QUOT = '1;
    typedef enum logic [1:0] {IDLE, ITER, FIX, RESP} state_e;
endpackage

// File: rtl/div_share_sched_if.sv
// div_share_sched_if: two request channels and one tagged response channel
// of the shared divider.
interface div_share_sched_if #(parameter int DW = 8, parameter int BW = 4);
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req1_a;
    logic [BW-1:0] req0_b, req1_b;
    logic          resp_valid, resp_ready, resp_id, resp_dbz;
    logic [DW-1:0] resp_quot, resp_rem;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_dbz
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_dbz
    );
endinterface

// File: rtl/div_ns_step.sv
// div_ns_step: one combinational non-restoring divide step on {rem_acc, q}.
module div_ns_step #(parameter int DW = 8, parameter int BW = 4) (
    input  logic [BW:0]   rem_acc,
    input  logic [DW-1:0] q,
    input  logic [BW-1:0] b,
    output logic [BW:0]   rem_nxt,
    output logic [DW-1:0] q_nxt
);
    logic [BW:0] sh, bx;
    assign sh      = {rem_acc[BW-1:0], q[DW-1]};
    assign bx      = {1'b0, b};
    assign rem_nxt = rem_acc[BW] ? sh + bx : sh - bx;
    assign q_nxt   = {q[DW-2:0], ~rem_nxt[BW]};
endmodule

// File: rtl/div_share_sched.sv
// div_share_sched: round-robin sharing of one iterative non-restoring divider
// between two requesters, with a tagged valid/ready response.
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    div_share_sched_if.slave  bus,
    output logic              busy
);
    localparam int CW = $clog2(DW);
    state_e        state_q, state_d;
    logic          rr_q, rr_d, id_q, id_d, dbz_q, dbz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW:0]   acc_q, acc_d, acc_nxt, acc_fix;
    logic [DW-1:0] q_q, q_d, q_nxt, quot_q, quot_d, rem_q, rem_d, gnt_a;
    logic [BW-1:0] b_q, b_d, gnt_b;
    logic          gnt_id, gnt_valid;
    div_ns_step #(.DW(DW), .BW(BW)) u_step (
        .rem_acc(acc_q), .q(q_q), .b(b_q), .rem_nxt(acc_nxt), .q_nxt(q_nxt)
    );
    // Ready is masked during reset so nothing can look accepted while state is forced
    assign gnt_id         = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
    assign gnt_valid      = rst_n & (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
    assign gnt_a          = gnt_id ? bus.req1_a : bus.req0_a;
    assign gnt_b          = gnt_id ? bus.req1_b : bus.req0_b;
    assign acc_fix        = acc_q[BW] ? acc_q + {1'b0, b_q} : acc_q;
    assign bus.req0_ready = gnt_valid & ~gnt_id;
    assign bus.req1_ready = gnt_valid & gnt_id;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_id    = id_q;
    assign bus.resp_quot  = quot_q;
    assign bus.resp_rem   = rem_q;
    assign bus.resp_dbz   = dbz_q;
    assign busy           = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: if (gnt_valid) begin
                rr_d    = ~gnt_id;
                id_d    = gnt_id;
                b_d     = gnt_b;
                state_d = (gnt_b == '0) ? RESP : ITER;
                quot_d  = (gnt_b == '0) ? DBZ_QUOT[DW-1:0] : quot_q;
                rem_d   = (gnt_b == '0) ? gnt_a : rem_q;
                dbz_d   = (gnt_b == '0) ? 1'b1 : dbz_q;
                acc_d   = '0;
                q_d     = gnt_a;
                cnt_d   = '0;
            end
            ITER: begin
                acc_d   = acc_nxt;
                q_d     = q_nxt;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(DW - 1)) ? FIX : ITER;
            end
            FIX: begin
                quot_d  = q_q;
                rem_d   = {{(DW-BW){1'b0}}, acc_fix[BW-1:0]};
                dbz_d   = 1'b0;
                state_d = RESP;
            end
            RESP: state_d = bus.resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Sequencing and arbitration controller for the team's 8-bit / 4-bit non-restoring divider datapath.
- Shares one iterative divide engine between two requesters using round-robin arbitration.
- Issues one non-restoring step per cycle, then applies the final remainder correction.
- Returns the quotient and remainder over a valid/ready response channel tagged with the requester ID.

Parameters:
- DW, 8, dividend and quotient width; also the iteration count.
- BW, 4, divisor width; BW < DW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 is accepted this cycle.
- req0_a  in  DW  requester 0 dividend.
- req0_b  in  BW  requester 0 divisor.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- resp_valid  out  1  response is held valid.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that owns the response.
- resp_quot  out  DW  quotient, A / B.
- resp_rem  out  DW  remainder, A % B, zero-extended.
- resp_dbz  out  1  divide-by-zero flag.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release of rst_n):
  - state=IDLE, rr_ptr=0, counter=0.
  - All resp_* outputs and busy are 0; both ready outputs are 0.
- States: IDLE, ITER, FIX, RESP.
- IDLE: the grant is combinational.
  - If both valid: grant requester rr_ptr.
  - Otherwise: grant whichever is valid.
  - reqN_ready=1 only for the granted requester. Ready may depend on valid; valid must not depend on ready.
- Handshake: on valid&ready, latch A, B and the ID.
  - Toggle rr_ptr to the non-granted requester. rr_ptr changes only on a grant.
  - If B==0: go to RESP with quot=all-ones, rem={0,A}, dbz=1.
  - Else: go to ITER with rem_acc=0 (BW+1 bits, signed), q=A, counter=0.
- ITER, one non-restoring step per cycle:
  - Shift {rem_acc,q} left by 1.
  - If rem_acc was non-negative before the shift, subtract B; otherwise add B.
  - New q LSB = ~sign(rem_acc).
  - Increment counter. After the step with counter==DW-1, go to FIX.
- FIX (one cycle): if rem_acc is negative, add B. Register the outputs and go to RESP.
- RESP: resp_valid=1; resp_quot, resp_rem, resp_id and resp_dbz are held stable.
  - When resp_ready=1, clear resp_valid next cycle and go to IDLE.
  - No new grant is made in the cycle resp_ready is accepted.
- Latency from the accept edge to resp_valid:
  - Normal: DW+1 cycles, which is 9 ITER+FIX edges with default parameters.
  - Divide-by-zero: 1 cycle.
- Throughput: one operation per DW+3 cycles minimum (default 11).
- Width rules:
  - rem_acc is BW+1 bits, two's complement. Add/subtract use the divisor zero-extended to BW+1.
  - resp_rem upper DW-BW bits are always 0, except the dbz case.
- Boundary conditions:
  - Request inputs changing while busy are ignored; the latched copies are used.
  - Requester valid deasserted before grant: no operation, no rr_ptr change.
  - resp_ready high when resp_valid is low has no effect.
  - rst_n asserted mid-ITER, FIX or RESP: immediate return to the reset state and the operation is lost; no response is produced.

Decomposition:
- Package div_share_pkg holds:
  - the state enum (IDLE, ITER, FIX, RESP);
  - DW/BW default constants;
  - the DBZ_QUOT all-ones constant.
- Sub-module div_ns_step: purely combinational single non-restoring step.
  - Inputs: rem_acc, q, b.
  - Outputs: next rem_acc, next q.
  - Instantiated once. The FIX correction stays in the top module.

Test Plan:
- req0 A=200, B=7, resp_ready=1 -> resp_valid 9 cycles after accept; quot=28, rem=4, id=0, dbz=0.
- req1 A=255, B=15 -> quot=17, rem=0, id=1. Then A=3, B=9 -> quot=0, rem=3.
- req0 A=13, B=0 -> resp_valid 1 cycle after accept; quot=0xFF, rem=13, dbz=1. No ITER cycles (busy pattern checked).
- Both valid continuously from reset, resp_ready=1 -> grant order 0,1,0,1; resp_id alternates. Ready never high for both, and never high outside IDLE.
- resp_ready=0 for 5 cycles in RESP -> outputs stable, no new grant, both readys 0. resp_ready=1 -> next cycle IDLE and grant.
- rst_n low at ITER counter=4 -> all outputs 0 immediately. After release, a fresh A=100, B=3 gives quot=33, rem=1.
